// File: rtl/filter_chain_ctrl_if.sv
// Control bundle between the filter-chain sequencer and the sync/producer/filter side.
// master = sequencer, slave = surrounding pixel pipeline.
interface filter_chain_ctrl_if #(
  parameter int LVL_W = 8
);
  logic             vblank_start;
  logic             visible;
  logic             src_valid;
  logic             thresh_en_req;
  logic             bright_en_req;
  logic             bright_up;
  logic             bright_down;
  logic             thresh_set_valid;
  logic [7:0]       thresh_set_value;
  logic             src_req;
  logic             src_rewind;
  logic             thresh_en;
  logic             bright_en;
  logic [7:0]       thresh_level;
  logic [LVL_W-1:0] bright_level;
  logic             cfg_update;
  logic [18:0]      pix_count;
  logic [15:0]      frame_count;
  logic             frame_err;
  logic             underrun;
  logic [1:0]       state_dbg;

  modport master (
    input  vblank_start, visible, src_valid,
    input  thresh_en_req, bright_en_req,
    input  bright_up, bright_down,
    input  thresh_set_valid, thresh_set_value,
    output src_req, src_rewind,
    output thresh_en, bright_en,
    output thresh_level, bright_level,
    output cfg_update, pix_count, frame_count,
    output frame_err, underrun, state_dbg
  );

  modport slave (
    output vblank_start, visible, src_valid,
    output thresh_en_req, bright_en_req,
    output bright_up, bright_down,
    output thresh_set_valid, thresh_set_value,
    input  src_req, src_rewind,
    input  thresh_en, bright_en,
    input  thresh_level, bright_level,
    input  cfg_update, pix_count, frame_count,
    input  frame_err, underrun, state_dbg
  );
endinterface

// File: rtl/filter_chain_ctrl.sv
// Frame-synchronous sequencer for ROM producer -> threshold -> brightness -> VGA.
// Shadow config is committed to the filter stages only at vertical blank.
module filter_chain_ctrl #(
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int LVL_W          = 8,
  parameter int LVL_STEP       = 16,
  parameter int LVL_DEFAULT    = 0,
  parameter int THRESH_DEFAULT = 128,
  parameter int PIPE_LAT       = 2
) (
  input logic                 clk,
  input logic                 reset,
  filter_chain_ctrl_if.master bus
);

  localparam logic [18:0] PIX_FULL = 19'(IMG_W * IMG_H);
  localparam logic [18:0] PIX_LAST = 19'(IMG_W * IMG_H - 1);
  localparam int          DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(LVL_DEFAULT);
  localparam logic [LVL_W-1:0] STEP    = LVL_W'(LVL_STEP);
  localparam logic [7:0]       THR_RST = 8'(THRESH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [18:0]      pix, pix_n;
  logic [DW-1:0]    drain_cnt, drain_n;
  logic             pending, pending_n;
  logic             commit, frame_inc, short_fr;
  logic [15:0]      frame_cnt;
  logic             frame_err, underrun;
  logic             cfg_update, src_rewind;
  logic             src_req;

  logic             sh_ten, sh_ben;
  logic [7:0]       sh_thr;
  logic [LVL_W-1:0] sh_lvl, sh_lvl_n;
  logic [LVL_W:0]   lvl_up;

  logic             c_ten, c_ben;
  logic [7:0]       c_thr;
  logic [LVL_W-1:0] c_lvl;

  assign src_req = bus.visible &
                   ((state == ARMED) | (state == STREAM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pix_n     = pix;
    drain_n   = drain_cnt;
    pending_n = pending;
    commit    = 1'b0;
    frame_inc = 1'b0;
    short_fr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.vblank_start) begin
          commit  = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (bus.visible) begin
          pix_n   = 19'd1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (bus.vblank_start) begin
          short_fr = 1'b1;
          commit   = 1'b1;
          state_n  = ARMED;
        end else if (bus.visible) begin
          if (pix == PIX_LAST) begin
            pix_n     = PIX_FULL;
            frame_inc = 1'b1;
            drain_n   = '0;
            pending_n = 1'b0;
            state_n   = DRAIN;
          end else begin
            pix_n = pix + 19'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          pending_n = 1'b0;
          if (pending | bus.vblank_start) begin
            commit  = 1'b1;
            state_n = ARMED;
          end else begin
            state_n = IDLE;
          end
        end else begin
          drain_n = drain_cnt + DW'(1);
          if (bus.vblank_start) pending_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (commit) pix_n = '0;
  end

  // Saturating level step; simultaneous up/down cancels.
  always_comb begin
    lvl_up   = {1'b0, sh_lvl} + {1'b0, STEP};
    sh_lvl_n = sh_lvl;
    if (bus.bright_up & ~bus.bright_down)
      sh_lvl_n = lvl_up[LVL_W] ? '1 : lvl_up[LVL_W-1:0];
    else if (bus.bright_down & ~bus.bright_up)
      sh_lvl_n = (sh_lvl < STEP) ? '0 : sh_lvl - STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix        <= '0;
      drain_cnt  <= '0;
      pending    <= 1'b0;
      frame_cnt  <= '0;
      frame_err  <= 1'b0;
      underrun   <= 1'b0;
      cfg_update <= 1'b0;
      src_rewind <= 1'b0;
    end else begin
      pix        <= pix_n;
      drain_cnt  <= drain_n;
      pending    <= pending_n;
      cfg_update <= commit;
      src_rewind <= commit;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (short_fr) frame_err <= 1'b1;
      if (src_req & ~bus.src_valid) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_ten <= 1'b0;
      sh_ben <= 1'b0;
      sh_thr <= THR_RST;
      sh_lvl <= LVL_RST;
      c_ten  <= 1'b0;
      c_ben  <= 1'b0;
      c_thr  <= THR_RST;
      c_lvl  <= LVL_RST;
    end else begin
      sh_ten <= bus.thresh_en_req;
      sh_ben <= bus.bright_en_req;
      sh_lvl <= sh_lvl_n;
      if (bus.thresh_set_valid) sh_thr <= bus.thresh_set_value;
      // Commit takes the pre-edge shadow, so same-cycle edits land next frame.
      if (commit) begin
        c_ten <= sh_ten;
        c_ben <= sh_ben;
        c_thr <= sh_thr;
        c_lvl <= sh_lvl;
      end
    end
  end

  assign bus.src_req      = src_req;
  assign bus.src_rewind   = src_rewind;
  assign bus.cfg_update   = cfg_update;
  assign bus.thresh_en    = c_ten;
  assign bus.bright_en    = c_ben;
  assign bus.thresh_level = c_thr;
  assign bus.bright_level = c_lvl;
  assign bus.pix_count    = pix;
  assign bus.frame_count  = frame_cnt;
  assign bus.frame_err    = frame_err;
  assign bus.underrun     = underrun;
  assign bus.state_dbg    = state;

endmodule
